upsampler: RTL
==============

// Module: upsampler
// PURPOSE
//  Inverse of the 2x2 decimating front end: takes a downsampled raster (IN_COLS x IN_ROWS, 8-bit)
//  and rebuilds full-resolution 2*IN_COLS x 2*IN_ROWS video by 2x2 pixel replication.
//  Sits between the feature-processing pipeline and the video output path.
//  A one-line buffer is used so each input line is consumed once and replayed for the odd output row.
// PARAMETERS
//  IN_COLS     400  input pixels per line (output line = 2*IN_COLS)
//  IN_ROWS     300  input lines per frame (output frame = 2*IN_ROWS lines)
//  DATA_WIDTH  8    pixel width
// PORTS
//  clock       in   1           single clock, all logic rising-edge
//  reset       in   1           asynchronous, active-high
//  valid       in   1           input pixel present on data
//  data        in   DATA_WIDTH  downsampled pixel, raster order
//  inready     out  1           block accepts data this cycle (transfer = valid && inready)
//  outready    in   1           sink consumes dataout this cycle (transfer = validout && outready)
//  dataout     out  DATA_WIDTH  full-resolution pixel
//  validout    out  1           dataout holds a pixel
//  framestart  out  1           qualifies dataout as pixel (row 0, col 0); only meaningful with validout
//  lineend     out  1           qualifies dataout as last pixel of an output line (col 2*IN_COLS-1)
// BEHAVIOUR
//  - Reset (async): dataout=0, validout=0, framestart=0, lineend=0, state=FILL, out_col=0, out_row=0.
//    Buffer contents not reset. Reset mid-frame discards everything; restart at row 0 col 0.
//  - Counters out_col (0..2*IN_COLS-1), out_row (0..2*IN_ROWS-1) = position of NEXT pixel to load.
//  - Output register loads when load_en = !validout || outready. It holds (no change) while stalled.
//  - States: FILL (even out_row), REPLAY (odd out_row).
//  - FILL, out_col even: inready = load_en. On transfer: buf[out_col>>1] <= data, dataout <= data,
//    validout <= 1, out_col++. No valid -> validout <= 0 if load_en, counters hold.
//  - FILL, out_col odd: inready=0; if load_en: dataout unchanged (repeat), validout <= 1, out_col++.
//  - REPLAY: inready=0 always. If load_en: dataout <= buf[out_col>>1] (combinational read),
//    validout <= 1, out_col++. Never bubbles.
//  - Line wrap: loading out_col=2*IN_COLS-1 sets lineend, out_col->0, state toggles.
//    FILL->REPLAY keeps out_row+1; REPLAY->FILL advances out_row+1; at out_row=2*IN_ROWS-1 wraps to 0.
//  - framestart set on the load with out_row=0, out_col=0; lineend/framestart cleared on any other load.
//  - Latency: input accepted in cycle N is on dataout in N+1. Second copy follows one output transfer later.
//  - Throughput: 1 output pixel/cycle with outready=1 and input always valid; input duty = 1/4 overall.
//  - Buffer write (FILL) and read (REPLAY) never in same cycle; buffer = IN_COLS x DATA_WIDTH.
//  - Counter widths: clog2(2*IN_COLS), clog2(2*IN_ROWS); no overflow past wrap values.
// TESTING
//  1 Assert reset mid-run -> next cycle validout=0, dataout=0, inready=1 once reset released.
//  2 One line data=col%256, valid=1, outready=1 -> dataout 0,0,1,1,..,143,143,0,0..; then 800-cycle
//    replay identical, inready=0 throughout, lineend on pixels 799 and 1599.
//  3 outready pattern 1,0,0,1 repeated -> dataout stable while stalled; sequence identical to test 2.
//  4 valid low 3 cycles every 5 -> validout bubbles only in FILL even columns; no pixel lost/duplicated.
//  5 Full 400x300 frame x2 -> exactly 480000 output pixels per frame, framestart exactly at pixel 0
//    of each frame, row 2k+1 equals row 2k.
//  6 Reset after 123 input pixels of row 5 -> outputs restart at row 0 col 0, framestart on first load.

Source files
------------

// File: rtl/upsampler.sv
// upsampler: rebuilds full-resolution video from a 2x2-decimated raster by
// replicating every input pixel horizontally (each pixel emitted twice) and
// vertically (each line replayed once from a one-line buffer).
// Even output rows come straight from the input stream (FILL), odd output
// rows are read back from the line buffer (REPLAY) with the input stalled.
module upsampler #(
    parameter int IN_COLS    = 400,
    parameter int IN_ROWS    = 300,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  inready,
    input  logic                  outready,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  validout,
    output logic                  framestart,
    output logic                  lineend
);

    localparam int COL_W = $clog2(2 * IN_COLS);
    localparam int ROW_W = $clog2(2 * IN_ROWS);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(2 * IN_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(2 * IN_ROWS - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    typedef enum logic {
        FILL,
        REPLAY
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [COL_W-1:0]        out_col;
    logic [COL_W-1:0]        out_col_n;
    logic [ROW_W-1:0]        out_row;
    logic [ROW_W-1:0]        out_row_n;
    logic [DATA_WIDTH-1:0]   dataout_n;
    logic                    validout_n;
    logic                    framestart_n;
    logic                    lineend_n;

    logic                    load_en;
    logic                    write_en;
    logic                    do_load;
    logic [COL_W-2:0]        buf_idx;
    logic [DATA_WIDTH-1:0]   rd_data;

    // One entry per input pixel; holds the current input line for the replay row.
    logic [DATA_WIDTH-1:0]   line_buf [0:IN_COLS-1];

    // Both copies of an input pixel share one buffer slot, so drop the column LSB.
    assign buf_idx  = out_col[COL_W-1:1];
    assign rd_data  = line_buf[buf_idx];

    // The output register may load whenever it is empty or being drained.
    assign load_en  = !validout || outready;

    // Fresh input is only needed on the first copy of each pixel of a FILL row.
    assign inready  = (state == FILL) && !out_col[0] && load_en;
    assign write_en = valid && inready;

    // Capture each accepted input pixel so the following odd row can replay it.
    always_ff @(posedge clock) begin
        if (write_en) begin
            line_buf[buf_idx] <= data;
        end
    end

    // Next-state logic: decide whether the output register loads, what it
    // loads, and how the raster position and FILL/REPLAY phase advance.
    always_comb begin
        state_n      = state;
        out_col_n    = out_col;
        out_row_n    = out_row;
        dataout_n    = dataout;
        validout_n   = validout;
        framestart_n = framestart;
        lineend_n    = lineend;
        do_load      = 1'b0;

        case (state)
            FILL: begin
                if (!out_col[0]) begin
                    if (write_en) begin
                        do_load   = 1'b1;
                        dataout_n = data;
                    end else if (load_en) begin
                        // No input available: emit a bubble, position holds.
                        validout_n = 1'b0;
                    end
                end else if (load_en) begin
                    // Second horizontal copy: dataout already holds the pixel.
                    do_load = 1'b1;
                end
            end
            REPLAY: begin
                if (load_en) begin
                    do_load   = 1'b1;
                    dataout_n = rd_data;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase

        if (do_load) begin
            validout_n   = 1'b1;
            framestart_n = (out_row == '0) && (out_col == '0);
            lineend_n    = (out_col == LAST_COL);
            if (out_col == LAST_COL) begin
                out_col_n = '0;
                state_n   = (state == FILL) ? REPLAY : FILL;
                if (out_row == LAST_ROW) begin
                    out_row_n = '0;
                end else begin
                    out_row_n = out_row + ROW_ONE;
                end
            end else begin
                out_col_n = out_col + COL_ONE;
            end
        end
    end

    // State, raster position and output register; reset discards the frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            out_col    <= '0;
            out_row    <= '0;
            dataout    <= '0;
            validout   <= 1'b0;
            framestart <= 1'b0;
            lineend    <= 1'b0;
        end else begin
            state      <= state_n;
            out_col    <= out_col_n;
            out_row    <= out_row_n;
            dataout    <= dataout_n;
            validout   <= validout_n;
            framestart <= framestart_n;
            lineend    <= lineend_n;
        end
    end

endmodule
